// File: rtl/mem_pkg.sv
// Shared memory package: default geometry and read-controller FSM encoding.
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DATA_DEPTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/mem_rd_skid_buf.sv
// Two-entry valid/ready buffer; the caller's credit logic guarantees a push
// never lands on a full buffer unless a pop frees a slot in the same cycle.
module mem_rd_skid_buf #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   occ_o
);

    logic [1:0][W-1:0] ent_q;
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        cnt_q;
    logic              pop;

    assign valid_o = (cnt_q != 2'd0);
    assign pop     = valid_o & ready_i;
    assign data_o  = ent_q[rd_ptr_q];
    assign occ_o   = cnt_q;

    // Storage, pointers and occupancy; entries are cleared so data reads 0 after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                ent_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read controller: issues addresses to a registered-read memory under a
// 2-word credit and streams the returned words with a last flag.
module mem_burst_reader
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o
);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  issue_rem_q;
    logic [LEN_WIDTH-1:0]  cap_cnt_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  inflight_q;
    logic                  done_q, done_d;
    logic [1:0]            occ;
    logic                  pop;
    logic [2:0]            load;
    logic                  issue;
    logic                  accept;
    logic                  cap_last;
    logic [DATA_WIDTH:0]   buf_data;

    assign accept = (state_q == ST_IDLE) && start_i && (len_i != '0);
    assign pop    = m_valid_o & m_ready_i;
    // pop implies occ >= 1, so the subtraction cannot underflow.
    assign load   = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue  = (state_q == ST_RUN) && (load < 3'd2);
    // Capture count is the number of words already written; this one is last
    // when it brings the count up to the burst length.
    assign cap_last = (cap_cnt_q + LEN_WIDTH'(1)) == len_q;

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign mem_rd_addr_o = addr_q;
    assign m_data_o      = buf_data[DATA_WIDTH-1:0];
    assign m_last_o      = buf_data[DATA_WIDTH];

    mem_rd_skid_buf #(
        .W (DATA_WIDTH + 1)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i ({cap_last, mem_rd_data_i}),
        .valid_o     (m_valid_o),
        .ready_i     (m_ready_i),
        .data_o      (buf_data),
        .occ_o       (occ)
    );

    // State and done pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next-state: RUN until the last address goes out, DRAIN until the last word leaves.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) state_d = ST_RUN;
                    else             done_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (issue && (issue_rem_q == LEN_WIDTH'(1)))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && m_last_o) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address, issue/capture counters and the one-cycle inflight flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            issue_rem_q <= '0;
            cap_cnt_q   <= '0;
            len_q       <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (accept) begin
                addr_q      <= start_addr_i;
                issue_rem_q <= len_i;
                cap_cnt_q   <= '0;
                len_q       <= len_i;
            end else begin
                if (issue) begin
                    addr_q      <= (addr_q == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
                    issue_rem_q <= issue_rem_q - LEN_WIDTH'(1);
                end
                if (inflight_q)
                    cap_cnt_q <= cap_cnt_q + LEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader with a registered-read memory model.
module tb_mem_burst_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] saddr = '0;
    logic [5:0] len = '0;
    logic       busy, done;
    logic [4:0] rd_addr;
    logic [7:0] rd_data = '0;
    logic       m_valid, m_last;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;

    logic [7:0] mem [32];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc = 0;
    int t0  = 0;
    logic [4:0] cur_saddr = '0;

    logic [7:0] got_d [$];
    logic       got_l [$];
    int  acc, first_rel, done_rel, done_cnt, stab_err, ahead_max;
    logic busy_seen, valid_seen, hold;
    logic [7:0] hold_d;
    logic hold_l;

    logic       rdy_mode = 1'b0;
    logic [5:0] rpat = 6'b101001;
    int         pidx = 0;

    mem_burst_reader dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .start_addr_i  (saddr),
        .len_i         (len),
        .busy_o        (busy),
        .done_o        (done),
        .mem_rd_addr_o (rd_addr),
        .mem_rd_data_i (rd_data),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .m_data_o      (m_data),
        .m_last_o      (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rd_data <= mem[rd_addr];
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            m_ready = rpat[pidx];
            pidx    = (pidx + 1) % 6;
        end else begin
            m_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int ahead;
            if (busy)    busy_seen  = 1'b1;
            if (m_valid) valid_seen = 1'b1;
            if (hold && (!m_valid || m_data != hold_d || m_last != hold_l)) stab_err++;
            if (busy) begin
                ahead = int'(5'(rd_addr - cur_saddr)) - acc;
                if (ahead > ahead_max) ahead_max = ahead;
            end
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
                if (acc == 0) first_rel = cyc - t0;
                acc++;
            end
            hold   = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        got_d.delete();
        got_l.delete();
        acc = 0; first_rel = -1; done_rel = -1; done_cnt = 0;
        stab_err = 0; ahead_max = 0;
        busy_seen = 1'b0; valid_seen = 1'b0; hold = 1'b0;
    endtask

    task automatic start_burst(input logic [4:0] a, input logic [5:0] l);
        @(posedge clk); #1;
        start = 1'b1; saddr = a; len = l;
        t0 = cyc; cur_saddr = a;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int i;
        for (i = 0; i < maxc; i++) begin
            @(posedge clk);
            if (done_cnt != 0) break;
        end
        if (i == maxc) chk({tag, "_timeout"}, 0, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic chk_words(input string tag, input int a, input int l);
        chk({tag, "_count"}, got_d.size(), l);
        for (int i = 0; i < l && i < got_d.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), got_d[i], 32'(((a + i) % 32) + 16));
            chk($sformatf("%s_l%0d", tag, i), got_l[i], (i == l - 1) ? 1 : 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i + 16);
        clear_mon();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_addr", rd_addr, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // basic burst with latency and done timing
        clear_mon();
        start_burst(5'd4, 6'd5);
        wait_done("b5", 40);
        chk_words("b5", 4, 5);
        chk("b5_first_rel", first_rel, 3);
        chk("b5_done_rel", done_rel, 8);
        chk("b5_done_cnt", done_cnt, 1);
        chk("b5_busy_end", busy, 0);

        // address wrap, plus a start during the burst that must be ignored
        clear_mon();
        start_burst(5'd30, 6'd4);
        @(posedge clk); #1;
        start = 1'b1; saddr = 5'd0; len = 6'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("wrap", 40);
        repeat (6) @(posedge clk);
        chk_words("wrap", 30, 4);
        chk("wrap_done_cnt", done_cnt, 1);

        // backpressure pattern
        clear_mon();
        rdy_mode = 1'b1; pidx = 0;
        start_burst(5'd0, 6'd8);
        wait_done("bp", 100);
        rdy_mode = 1'b0;
        chk_words("bp", 0, 8);
        chk("bp_stable_err", stab_err, 0);
        chk("bp_ahead_le3", (ahead_max <= 3) ? 1 : 0, 1);

        // zero-length burst
        clear_mon();
        start_burst(5'd3, 6'd0);
        wait_done("z", 10);
        chk("z_done_rel", done_rel, 1);
        chk("z_busy_seen", busy_seen, 0);
        chk("z_valid_seen", valid_seen, 0);

        // reset mid-burst
        clear_mon();
        start_burst(5'd0, 6'd10);
        for (int i = 0; i < 20 && acc < 2; i++) @(posedge clk);
        chk("mid_acc", (acc >= 2) ? 1 : 0, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_valid", m_valid, 0);
        chk("mid_data", m_data, 0);
        chk("mid_last", m_last, 0);
        chk("mid_addr", rd_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("mid_no_done", done_cnt, 0);
        clear_mon();
        start_burst(5'd8, 6'd3);
        wait_done("post", 40);
        chk_words("post", 8, 3);

        // full-depth burst at full throughput
        clear_mon();
        start_burst(5'd0, 6'd32);
        wait_done("full", 80);
        chk_words("full", 0, 32);
        chk("full_first_rel", first_rel, 3);
        chk("full_done_rel", done_rel, 35);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_burst_reader.md
# mem_burst_reader

Read-side controller for the team's dual-port memory: accepts a burst command (start address, length), drives the memory read address port, absorbs its one-cycle registered read latency, and presents the words as a valid/ready stream with a last flag. Sits between `dual_port_mem`'s read port and downstream consumers; runs entirely on the read clock.

## Interface
- DATA_WIDTH, 8, word width; matches the memory's word width
- DATA_DEPTH, 32, memory depth in words
- ADDR_WIDTH, $clog2(DATA_DEPTH), memory address width
- LEN_WIDTH, ADDR_WIDTH+1, burst length width; a full-depth burst is legal
- clk_i  input  1  single clock (memory read clock)
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  burst request; sampled only in IDLE
- start_addr_i  input  ADDR_WIDTH  first word address
- len_i  input  LEN_WIDTH  number of words, 0..2^LEN_WIDTH-1
- busy_o  output  1  high from the cycle after an accepted start until done_o
- done_o  output  1  one-cycle pulse at burst completion
- mem_rd_addr_o  output  ADDR_WIDTH  to the memory read address port
- mem_rd_data_i  input  DATA_WIDTH  from the memory; valid one cycle after the address
- m_valid_o  output  1  stream data valid
- m_ready_i  input  1  stream ready
- m_data_o  output  DATA_WIDTH  stream data
- m_last_o  output  1  marks the final word of the burst; qualified by m_valid_o

## Operation
- Reset values: busy_o=0, done_o=0, m_valid_o=0, m_data_o=0, m_last_o=0, mem_rd_addr_o=0. All counters clear, buffer empty, FSM in IDLE.
- FSM states:
  - IDLE: start_i=1 with len_i>0 goes to RUN and loads the address and issue/accept counters. start_i=1 with len_i=0 pulses done_o on the next cycle and stays in IDLE; busy_o never rises.
  - RUN: issue one address per cycle while credit allows. Go to DRAIN when the last address has been issued.
  - DRAIN: go to IDLE when the final word has been handshaked. done_o pulses on the IDLE entry cycle.
- Issue rule: a read is issued in a cycle when (occupancy − pop + inflight) < 2.
  - occupancy: words in the 2-entry output buffer.
  - pop: m_valid_o & m_ready_i.
  - inflight: 1 if an address was issued in the previous cycle.
- Capture: mem_rd_data_i is written into the buffer exactly in the cycle after an issue. Memory data in any other cycle is ignored.
- Address wraps: DATA_DEPTH-1 is followed by 0 (explicit compare, so non-power-of-two depths work). len_i > DATA_DEPTH re-reads wrapped words; this is legal.
- m_last_o is set on the word whose accept count equals len_i.
- start_i while busy is ignored. No abort input exists.
- Reset mid-burst: the buffer is discarded and no done_o is produced.
- Stream rule: once m_valid_o is high, m_data_o and m_last_o stay stable until the handshake.

## Timing
- Cycle 0: start_i sampled high.
- Cycle 1: busy_o=1, mem_rd_addr_o=start_addr_i.
- Cycle 2: memory data returns.
- Cycle 3: first m_valid_o (start-to-first-valid latency is 3).
- With m_ready_i held high: one word per cycle, no bubbles. The last word is at cycle 3+len−1; done_o and busy_o=0 follow in the next cycle.
- Next start is accepted in the cycle done_o is high, so back-to-back bursts have a 1-cycle gap.
- Under m_ready_i=0: at most 2 words are buffered, and at most 1 read is in flight before the buffer fills. No word is lost or duplicated.

## Structure
- Shared package `mem_pkg`: FSM state encodings (IDLE/RUN/DRAIN) and the default DATA_WIDTH/DATA_DEPTH, shared with `dual_port_mem` instantiations.
- Sub-module `mem_rd_skid_buf`: a 2-entry valid/ready buffer carrying {last, data}, with an occupancy output.
- Top level holds the FSM, address/issue/accept counters, the credit logic and the inflight flag.

## Test plan
- Memory preloaded with mem[i]=i+0x10. start_addr=4, len=5, ready=1 → data 0x14..0x18 on cycles 3..7, last on 0x18, done_o on cycle 8.
- start_addr=30, len=4, DATA_DEPTH=32 → addresses 30, 31, 0, 1; data 0x2E, 0x2F, 0x10, 0x11.
- len=8 with m_ready_i pattern 1,0,0,1,0,1… → all 8 words in order, none duplicated; mem_rd_addr_o never more than 3 words ahead of accepted words.
- len=0 → done_o pulses one cycle after start, busy_o and m_valid_o stay 0. A start asserted during a burst → ignored.
- rst_i asserted mid-burst (2 words accepted) → all outputs at reset values immediately, no done_o; a following burst runs normally.
- len=32, start_addr=0 → all 32 words, last on word 31, full throughput.
